// File: rtl/gf_exp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gf_exp_sequencer
// Description : Computes result = base^exp in GF(2^8) (poly 0x11D) by
//               left-to-right square-and-multiply. The squarer and
//               multiplier are external combinational blocks; this module
//               drives their operands and keeps the accumulator.
//               exp=254 yields the multiplicative inverse of base.
// Ports       :
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous active-high reset
//   start  in   1      job request, sampled only in IDLE
//   base   in   8      field element, captured on accepted start
//   exp    in   EXP_W  exponent, captured on accepted start
//   busy   out  1      high while in SQ, MUL or DONE
//   done   out  1      one-cycle pulse, result valid in that cycle
//   result out  8      base^exp, held until the next job completes
//   sq_k   out  8      squarer operand (accumulator)
//   sq_q   in   8      squarer output (acc^2)
//   mul_a  out  8      multiplier operand A (accumulator)
//   mul_b  out  8      multiplier operand B (captured base)
//   mul_q  in   8      multiplier output (acc*base)
// Revision    : 1.0  initial release
// ============================================================================
module gf_exp_sequencer #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic [7:0]       sq_k,
    input  logic [7:0]       sq_q,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [7:0]       mul_q
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQ   = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       acc_q;
    logic [7:0]       base_q;
    logic [EXP_W-1:0] exp_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       result_q;

    // Datapath operands come straight from registers so that no input port
    // has a combinational path into the external squarer/multiplier.
    assign sq_k   = acc_q;
    assign mul_a  = acc_q;
    assign mul_b  = base_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= 8'h01;
            base_q   <= 8'h00;
            exp_q    <= '0;
            idx_q    <= IDX_TOP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base;
                        exp_q   <= exp;
                        acc_q   <= 8'h01;
                        idx_q   <= IDX_TOP;
                        busy_q  <= 1'b1;
                        state_q <= S_SQ;
                    end
                end
                S_SQ: begin
                    acc_q <= sq_q;
                    if (exp_q[idx_q]) begin
                        state_q <= S_MUL;
                    end else if (idx_q == '0) begin
                        // Capture the final value on the way into DONE.
                        result_q <= sq_q;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q   <= idx_q - IDX_ONE;
                        state_q <= S_SQ;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_q;
                    if (idx_q == '0) begin
                        result_q <= mul_q;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q   <= idx_q - IDX_ONE;
                        state_q <= S_SQ;
                    end
                end
                S_DONE: begin
                    // done is registered from this state, so the pulse lands
                    // in the first IDLE cycle after DONE.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
